// File: rtl/fifo_stream_reader.sv
// Read-side adapter: drains a registered-output FIFO into a valid/ready stream via a 3-entry prefetch buffer.
// Optional delivered-word counter enabled by defining FIFO_RD_CNT_EN.
module fifo_stream_reader #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_pop,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]       word_cnt
`endif
);

    logic [1:0]        occ;
    logic [1:0]        head;
    logic [1:0]        tail;
    logic              inflight;
    logic [DATA_W-1:0] buf_mem [0:2];
    logic [2:0]        level;
    logic              capture;
    logic              fire;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pop decision uses only registered state and fifo_empty, never m_ready.
    always_comb begin
        level    = {1'b0, occ} + {2'b00, inflight};
        fifo_pop = !rst && !flush && !fifo_empty && (level < 3'd3);
        m_valid  = (occ != 2'd0);
        m_data   = buf_mem[head];
        fire     = m_valid && m_ready;
        capture  = inflight;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= 2'd0;
            head     <= 2'd0;
            tail     <= 2'd0;
            inflight <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (flush) begin
            // A word landing now is dropped; a same-cycle fire is moot once the buffer empties.
            occ      <= 2'd0;
            head     <= 2'd0;
            tail     <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_pop;
            if (capture) begin
                buf_mem[tail] <= fifo_dout;
                tail          <= next_ptr(tail);
            end
            if (fire) begin
                head <= next_ptr(head);
            end
            case ({capture, fire})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= 16'd0;
        end else if (fire) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule
